// File: rtl/tc_pl_cap_window_gen_if.sv
// Capture-window generator port bundle: trigger and latched parameters in,
// busy/gate/index/done status and miss count out.
interface tc_pl_cap_window_gen_if #(
    parameter int CAP0_10 = 18,
    parameter int CAP0_11 = 32
);
    logic               cap_trig;
    logic [CAP0_10-1:0] cap_gain_cycle;
    logic [CAP0_11-1:0] cap_gain_Lddel;
    logic               cap_busy;
    logic               cap_gate;
    logic [CAP0_10-1:0] cap_idx;
    logic               cap_done;
    logic [15:0]        trig_miss_cnt;

    modport master (
        output cap_trig, cap_gain_cycle, cap_gain_Lddel,
        input  cap_busy, cap_gate, cap_idx, cap_done, trig_miss_cnt
    );

    modport slave (
        input  cap_trig, cap_gain_cycle, cap_gain_Lddel,
        output cap_busy, cap_gate, cap_idx, cap_done, trig_miss_cnt
    );
endinterface

// File: rtl/tc_pl_cap_window_gen.sv
// Capture-window generator: on trigger, waits the latched load delay, then
// raises a capture gate with a sample index for the latched cycle count.
module tc_pl_cap_window_gen #(
    parameter int CAP0_10 = 18,
    parameter int CAP0_11 = 32
) (
    input logic                  clk,
    input logic                  rst,
    tc_pl_cap_window_gen_if.slave cap
);
    typedef enum logic [1:0] {IDLE, DELAY, GATE, DONE} state_t;

    localparam logic [CAP0_10-1:0] ONE_C = 1;
    localparam logic [CAP0_11-1:0] ONE_D = 1;

    state_t             state, state_nxt;
    logic [CAP0_11-1:0] lddel_r;
    logic [CAP0_10-1:0] cyc_r;
    logic [CAP0_11-1:0] dly_cnt, dly_cnt_nxt;
    logic [CAP0_10-1:0] idx_r, idx_nxt;
    logic               busy_r, busy_nxt;
    logic               gate_r, gate_nxt;
    logic               done_r, done_nxt;
    logic [15:0]        miss_cnt_r, miss_cnt_nxt;
    logic               accept;
    logic               miss;

    assign accept = (state == IDLE) && cap.cap_trig;
    assign miss   = (state != IDLE) && cap.cap_trig;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lddel_r    <= '0;
            cyc_r      <= '0;
            dly_cnt    <= '0;
            idx_r      <= '0;
            busy_r     <= 1'b0;
            gate_r     <= 1'b0;
            done_r     <= 1'b0;
            miss_cnt_r <= '0;
        end else begin
            state      <= state_nxt;
            dly_cnt    <= dly_cnt_nxt;
            idx_r      <= idx_nxt;
            busy_r     <= busy_nxt;
            gate_r     <= gate_nxt;
            done_r     <= done_nxt;
            miss_cnt_r <= miss_cnt_nxt;
            if (accept) begin
                lddel_r <= cap.cap_gain_Lddel;
                cyc_r   <= cap.cap_gain_cycle;
            end
        end
    end

    // The accepting edge decides from the live inputs, which are the values being latched.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cap.cap_trig) begin
                    if (cap.cap_gain_Lddel != '0)
                        state_nxt = DELAY;
                    else if (cap.cap_gain_cycle != '0)
                        state_nxt = GATE;
                    else
                        state_nxt = DONE;
                end
            end
            DELAY: begin
                if (dly_cnt == lddel_r)
                    state_nxt = (cyc_r != '0) ? GATE : DONE;
            end
            GATE: begin
                if (idx_r == cyc_r - ONE_C)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state they describe.
    always_comb begin
        busy_nxt     = (state_nxt != IDLE);
        gate_nxt     = (state_nxt == GATE);
        done_nxt     = (state_nxt == DONE);
        dly_cnt_nxt  = '0;
        idx_nxt      = '0;
        miss_cnt_nxt = miss_cnt_r;
        if (state_nxt == DELAY)
            dly_cnt_nxt = (state == DELAY) ? dly_cnt + ONE_D : ONE_D;
        if (state_nxt == GATE && state == GATE)
            idx_nxt = idx_r + ONE_C;
        if (miss && miss_cnt_r != '1)
            miss_cnt_nxt = miss_cnt_r + 16'd1;
    end

    assign cap.cap_busy      = busy_r;
    assign cap.cap_gate      = gate_r;
    assign cap.cap_idx       = idx_r;
    assign cap.cap_done      = done_r;
    assign cap.trig_miss_cnt = miss_cnt_r;
endmodule

// File: tb/tb_tc_pl_cap_window_gen.sv
// Scoreboard bench for tc_pl_cap_window_gen: expected per-cycle outputs are
// derived from the trigger timing rules and queued as stimulus is driven.
module tb_tc_pl_cap_window_gen;
    localparam int W_CYC = 18;
    localparam int W_DLY = 32;

    typedef struct {
        int   stamp;
        logic busy;
        logic gate;
        logic done;
        int   idx;
        int   miss;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    // Reference timing state: accept edge, latched L/C, earliest next accept edge, miss count.
    int   m_k = 0;
    int   m_l = 0;
    int   m_c = 0;
    int   m_nxt = 0;
    logic m_act = 1'b0;
    int   m_miss = 0;

    tc_pl_cap_window_gen_if #(.CAP0_10(W_CYC), .CAP0_11(W_DLY)) bus ();

    tc_pl_cap_window_gen #(.CAP0_10(W_CYC), .CAP0_11(W_DLY)) dut (
        .clk (clk),
        .rst (rst),
        .cap (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].stamp == cyc) begin
            mon_e = sb.pop_front();
            check_val("busy", {31'd0, bus.cap_busy}, {31'd0, mon_e.busy});
            check_val("gate", {31'd0, bus.cap_gate}, {31'd0, mon_e.gate});
            check_val("done", {31'd0, bus.cap_done}, {31'd0, mon_e.done});
            check_val("idx",  {14'd0, bus.cap_idx},  mon_e.idx);
            check_val("miss", {16'd0, bus.trig_miss_cnt}, mon_e.miss);
        end
    end

    // Drive one clock of stimulus and queue what the outputs must be after that edge.
    task automatic step(input logic r, input logic t, input int l, input int c);
        exp_t e;
        int   c0;
        int   j;
        int   span;
        c0 = cyc;
        rst = r;
        bus.cap_trig = t;
        bus.cap_gain_Lddel = l;
        bus.cap_gain_cycle = c[W_CYC-1:0];
        if (r) begin
            m_act  = 1'b0;
            m_miss = 0;
            m_nxt  = c0 + 1;
        end else if (t) begin
            if (c0 >= m_nxt) begin
                m_act = 1'b1;
                m_k   = c0;
                m_l   = l;
                m_c   = c;
                m_nxt = c0 + l + c + 2;
            end else if (m_miss != 65535) begin
                m_miss++;
            end
        end
        j    = c0 + 1 - m_k;
        span = m_l + m_c + 1;
        e.stamp = c0 + 1;
        e.busy  = m_act && j >= 1 && j <= span;
        e.gate  = m_act && j >= m_l + 1 && j <= m_l + m_c;
        e.done  = m_act && j == span;
        e.idx   = e.gate ? j - m_l - 1 : 0;
        e.miss  = m_miss;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input int l, input int c);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, l, c);
    endtask

    initial begin
        rst = 1'b1;
        bus.cap_trig = 1'b0;
        bus.cap_gain_cycle = '0;
        bus.cap_gain_Lddel = '0;
        @(negedge clk);

        // reset for 3 clocks with trigger asserted during it
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b1, 5, 4);
        step(1'b1, 1'b1, 5, 4);
        idle(6, 5, 4);

        // nominal L=5 C=4
        step(1'b0, 1'b1, 5, 4);
        idle(12, 5, 4);

        // zero cases
        step(1'b0, 1'b1, 0, 3);
        idle(6, 0, 3);
        step(1'b0, 1'b1, 7, 0);
        idle(10, 7, 0);
        step(1'b0, 1'b1, 0, 0);
        idle(3, 0, 0);

        // inputs change after acceptance
        step(1'b0, 1'b1, 2, 6);
        step(1'b0, 1'b0, 2, 6);
        idle(12, 100, 1);

        // trigger held high: accepts at k and k+7, misses in between
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 2, 3);
        idle(8, 2, 3);

        // reset in the 4th gate cycle, then a full window
        step(1'b0, 1'b1, 1, 10);
        idle(4, 1, 10);
        step(1'b1, 1'b0, 1, 10);
        step(1'b0, 1'b1, 1, 10);
        idle(13, 1, 10);

        // miss counter saturation: 65537 misses during one long delay
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 65540, 0);
        for (int i = 0; i < 65537; i++) step(1'b0, 1'b1, 65540, 0);
        idle(8, 65540, 0);

        repeat (2) @(negedge clk);
        #1;
        check_val("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
